// File: rtl/adc_framer_if.sv
// AXI-Stream master link from the ADC framer to the windowing stage.
// No backpressure path in practice: the windower holds tready high.
interface adc_framer_if #(
    parameter int CHANNELS = 2
);
    logic                    tvalid;
    logic [CHANNELS*16-1:0]  tdata;
    logic                    tlast;
    logic                    tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_framer.sv
// Cuts the free-running ADC sample stream into fixed-length AXIS frames with TLAST,
// single-shot or continuous with a programmable inter-frame gap.
//
// state   | meaning
// IDLE    | waiting for arm; nothing emitted
// CAPTURE | every adc_valid becomes one output beat; TLAST on beat len-1
// GAP     | continuous mode idle time between frames; samples discarded
module adc_framer #(
    parameter int CHANNELS = 2,
    parameter int LEN_W    = 12,
    parameter int GAP_W    = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [CHANNELS*16-1:0] adc_data,
    input  logic                   adc_valid,
    input  logic [LEN_W-1:0]       cfg_frame_len,
    input  logic [GAP_W-1:0]       cfg_gap,
    input  logic                   cfg_continuous,
    input  logic                   cfg_offset_bin,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   clr_status,
    adc_framer_if.master           m_axis,
    output logic                   busy,
    output logic                   ovf,
    output logic                   len_err,
    output logic [31:0]            frame_cnt
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] GAP     = 2'd2;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2048);

    logic [1:0]             state, state_nxt;
    logic [LEN_W-1:0]       len, beat_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   offset_bin, run, stop_pending;
    logic                   accept, last_beat, len_ok, relatch, len_err_evt, ovf_evt;
    logic [CHANNELS*16-1:0] data_conv;

    assign accept      = (state == CAPTURE) && adc_valid;
    assign last_beat   = (beat_cnt == len - LEN_W'(1));
    assign len_ok      = (cfg_frame_len != '0) && (cfg_frame_len <= MAX_LEN);
    assign ovf_evt     = m_axis.tvalid && !m_axis.tready;
    assign busy        = (state != IDLE);

    // Offset-binary to two's complement on a 10-bit sample is just an MSB flip.
    always_comb begin
        data_conv = adc_data;
        for (int i = 0; i < CHANNELS; i++) begin
            data_conv[i*16+9] = adc_data[i*16+9] ^ offset_bin;
        end
    end

    always_comb begin
        state_nxt   = state;
        relatch     = 1'b0;
        len_err_evt = 1'b0;
        case (state)
            IDLE: begin
                if (arm && !stop) begin
                    if (len_ok) begin
                        state_nxt = CAPTURE;
                        relatch   = 1'b1;
                    end else begin
                        len_err_evt = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (accept && last_beat) begin
                    if (!run || stop_pending || stop) begin
                        state_nxt = IDLE;
                    end else if (cfg_gap != '0) begin
                        state_nxt = GAP;
                    end else if (len_ok) begin
                        relatch = 1'b1;
                    end else begin
                        len_err_evt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            GAP: begin
                if (stop || stop_pending) begin
                    state_nxt = IDLE;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    if (len_ok) begin
                        relatch   = 1'b1;
                        state_nxt = CAPTURE;
                    end else begin
                        len_err_evt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            len           <= '0;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            offset_bin    <= 1'b0;
            run           <= 1'b0;
            stop_pending  <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            frame_cnt     <= '0;
            ovf           <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == CAPTURE) begin
                offset_bin <= cfg_offset_bin;
                run        <= cfg_continuous;
            end
            if (relatch) begin
                len <= cfg_frame_len;
            end
            if (state_nxt == IDLE) begin
                stop_pending <= 1'b0;
            end else if (stop && state != IDLE) begin
                stop_pending <= 1'b1;
            end
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + LEN_W'(1);
            end
            // Gap counter runs down to 1; the exit clock is the last idle clock.
            if (state == CAPTURE && state_nxt == GAP) begin
                gap_cnt <= cfg_gap;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            m_axis.tvalid <= accept;
            m_axis.tlast  <= accept && last_beat;
            if (accept) begin
                m_axis.tdata <= data_conv;
            end
            if (accept && last_beat) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            ovf     <= ovf_evt     | (ovf     & ~clr_status);
            len_err <= len_err_evt | (len_err & ~clr_status);
        end
    end
endmodule

// File: tb/tb_adc_framer.sv
// Bench for adc_framer: expected beats queued at drive time, popped when TVALID appears.
module tb_adc_framer;
    localparam int CH = 2;
    localparam int LW = 12;
    localparam int GW = 16;
    localparam int DW = CH*16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [LW-1:0] cfg_frame_len = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic          cfg_continuous = 1'b0;
    logic          cfg_offset_bin = 1'b0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          clr_status = 1'b0;
    logic          busy, ovf, len_err;
    logic [31:0]   frame_cnt;

    adc_framer_if #(.CHANNELS(CH)) axis ();

    adc_framer #(.CHANNELS(CH), .LEN_W(LW), .GAP_W(GW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_gap        (cfg_gap),
        .cfg_continuous (cfg_continuous),
        .cfg_offset_bin (cfg_offset_bin),
        .arm            (arm),
        .stop           (stop),
        .clr_status     (clr_status),
        .m_axis         (axis),
        .busy           (busy),
        .ovf            (ovf),
        .len_err        (len_err),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad = 0;
    logic [DW:0] sb[$];
    logic [DW:0] mon_exp;
    logic [15:0] seq = 16'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] conv(input logic [DW-1:0] d, input logic ob);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < CH; i++) r[i*16+9] = d[i*16+9] ^ ob;
        return r;
    endfunction

    task automatic drive_raw(input logic v, input logic [DW-1:0] d, input logic push,
                             input logic [DW:0] want);
        @(negedge clk);
        arm = 1'b0;
        stop = 1'b0;
        clr_status = 1'b0;
        adc_valid = v;
        adc_data = d;
        if (push) sb.push_back(want);
    endtask

    task automatic drive(input logic v, input logic push, input logic last);
        logic [DW-1:0] d;
        seq = seq + 16'd1;
        d = {~seq, seq};
        drive_raw(v, d, push, {last, conv(d, cfg_offset_bin)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rstn = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rstn && axis.tvalid) begin
            if (sb.size() == 0) begin
                chk("beat_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                chk("beat", 64'({axis.tlast, axis.tdata}), 64'(mon_exp));
            end
        end
    end

    initial begin
        axis.tready = 1'b1;
        #1;
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tdata", 64'(axis.tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        do_reset();

        // 1: single frame of 8, arm while busy has no effect
        cfg_frame_len = 12'd8; cfg_continuous = 1'b0; cfg_offset_bin = 1'b0;
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, k == 7);
            if (k == 3) begin
                arm = 1'b1;
                chk("t1_busy_mid", 64'(busy), 64'd1);
            end
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: continuous len 4, gap 3, stop during 2nd frame beat 2
        do_reset();
        cfg_frame_len = 12'd4; cfg_continuous = 1'b1; cfg_gap = 16'd3;
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            drive(1'b1, (i >= 1 && i <= 4) || (i >= 8 && i <= 11), i == 4 || i == 11);
            if (i == 9) stop = 1'b1;
        end
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("t2_busy_end", 64'(busy), 64'd0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // arm and stop together in IDLE: stop wins
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1; stop = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("armstop_busy", 64'(busy), 64'd0);

        // 3: 2048-beat frames back-to-back, then 50% valid single shot
        do_reset();
        cfg_frame_len = 12'd2048; cfg_continuous = 1'b1; cfg_gap = 16'd0;
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            drive(1'b1, 1'b1, (i % 2048) == 0);
            if (i == 3000) stop = 1'b1;
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("t3_busy_end", 64'(busy), 64'd0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);
        cfg_continuous = 1'b0;
        drive(1'b0, 1'b0, 1'b0); arm = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            drive(i[0], i[0], i == 4095);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t3_toggle_frame_cnt", 64'(frame_cnt), 64'd3);
        chk("t3_toggle_busy", 64'(busy), 64'd0);
        chk("t3_toggle_sb_empty", 64'(sb.size()), 64'd0);

        // 4: offset-binary conversion and length errors
        do_reset();
        cfg_frame_len = 12'd2; cfg_offset_bin = 1'b1;
        drive(1'b0, 1'b0, 1'b0); arm = 1'b1;
        drive_raw(1'b1, {16'h01FF, 16'h0200}, 1'b1, {1'b0, 16'h03FF, 16'h0000});
        drive_raw(1'b1, {16'h0200, 16'h01FF}, 1'b1, {1'b1, 16'h0000, 16'h03FF});
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_conv_sb_empty", 64'(sb.size()), 64'd0);
        cfg_offset_bin = 1'b0;
        cfg_frame_len = 12'd0;
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_len0_err", 64'(len_err), 64'd1);
        chk("t4_len0_busy", 64'(busy), 64'd0);
        clr_status = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_clr_err", 64'(len_err), 64'd0);
        cfg_frame_len = 12'd2049;
        arm = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_len2049_err", 64'(len_err), 64'd1);
        cfg_frame_len = 12'd0;
        arm = 1'b1; clr_status = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_clr_vs_new_err", 64'(len_err), 64'd1);

        // 5: TREADY drop mid-frame, then reset mid-frame
        do_reset();
        cfg_frame_len = 12'd8; cfg_continuous = 1'b0;
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, i == 8);
            axis.tready = (i != 5);
        end
        drive(1'b0, 1'b0, 1'b0);
        axis.tready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("t5_ovf", 64'(ovf), 64'd1);
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        clr_status = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("t5_ovf_clr", 64'(ovf), 64'd0);
        drive(1'b1, 1'b0, 1'b0); arm = 1'b1;
        for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("t5_rst_tlast", 64'(axis.tlast), 64'd0);
        chk("t5_rst_tdata", 64'(axis.tdata), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t5_rst_sb_empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
